// File: rtl/ad5781_spi_slave.sv
// AD5781-style SPI responder clocked by the system clock: oversampled SPI pins,
// 24-bit frame decode, DAC/CTRL/CLRCODE register bank and readback on miso.
module ad5781_spi_slave #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [19:0] CTRL_RST    = 20'h00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    input  logic        ldac_n,
    output logic [19:0] dac_out,
    output logic [19:0] ctrl_reg,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT_CS
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, ldac_sync_q;
    logic                   sclk_prev_q, cs_prev_q, ldac_prev_q;

    // Synchronizers keep sampling through reset so the FSM can see cs_n on release.
    always_ff @(posedge clk) begin
        sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ldac_sync_q <= {ldac_sync_q[SYNC_STAGES-2:0], ldac_n};
        sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        ldac_prev_q <= ldac_sync_q[SYNC_STAGES-1];
    end

    logic sclk_s, cs_s, mosi_s, ldac_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, ldac_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ldac_s    = ldac_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign ldac_fall = ~ldac_s & ldac_prev_q;

    state_t      state_q;
    logic [4:0]  bit_cnt_q;
    logic [23:0] rx_sr_q, tx_sr_q, rd_buf_q;
    logic        rd_pending_q, miso_q, frame_done_q, frame_err_q;
    logic [19:0] dac_reg_q, dac_out_q, ctrl_q, clrcode_q;

    logic        commit;
    logic        rx_rw;
    logic [2:0]  rx_addr;
    logic [19:0] rx_data, rd_data;

    assign rx_rw   = rx_sr_q[23];
    assign rx_addr = rx_sr_q[22:20];
    assign rx_data = rx_sr_q[19:0];
    assign commit  = (state_q == ST_SHIFT) && cs_rise && (bit_cnt_q == 5'd24);

    always_comb begin
        rd_data = '0;
        case (rx_addr)
            3'd1:    rd_data = dac_reg_q;
            3'd2:    rd_data = ctrl_q;
            3'd3:    rd_data = clrcode_q;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        frame_done_q <= 1'b0;
        frame_err_q  <= 1'b0;
        if (reset) begin
            state_q      <= cs_s ? ST_IDLE : ST_WAIT_CS;
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= '0;
            rd_buf_q     <= '0;
            rd_pending_q <= 1'b0;
            miso_q       <= 1'b0;
            dac_reg_q    <= '0;
            dac_out_q    <= '0;
            ctrl_q       <= CTRL_RST;
            clrcode_q    <= '0;
        end else begin
            if (ldac_fall && !commit)
                dac_out_q <= dac_reg_q;

            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_q      <= ST_SHIFT;
                        bit_cnt_q    <= '0;
                        tx_sr_q      <= rd_pending_q ? rd_buf_q : '0;
                        miso_q       <= rd_pending_q & rd_buf_q[23];
                        rd_pending_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state_q <= ST_IDLE;
                        miso_q  <= 1'b0;
                        if (bit_cnt_q == 5'd24)
                            frame_done_q <= 1'b1;
                        else
                            frame_err_q <= 1'b1;
                    end else begin
                        if (sclk_fall) begin
                            rx_sr_q   <= {rx_sr_q[22:0], mosi_s};
                            bit_cnt_q <= (bit_cnt_q == 5'd25) ? 5'd25 : bit_cnt_q + 5'd1;
                        end
                        if (sclk_rise) begin
                            tx_sr_q <= {tx_sr_q[22:0], 1'b0};
                            miso_q  <= tx_sr_q[22];
                        end
                    end
                end
                ST_WAIT_CS: begin
                    if (cs_rise)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // Placed after the ldac edge load so a commit in the same cycle takes priority.
            if (commit) begin
                if (rx_rw) begin
                    rd_buf_q     <= {1'b1, rx_addr, rd_data};
                    rd_pending_q <= 1'b1;
                end else begin
                    case (rx_addr)
                        3'd1: begin
                            dac_reg_q <= rx_data;
                            if (!ldac_s)
                                dac_out_q <= rx_data;
                        end
                        3'd2: ctrl_q    <= rx_data;
                        3'd3: clrcode_q <= rx_data;
                        3'd4: begin
                            if (rx_data[2]) begin
                                dac_reg_q <= '0;
                                dac_out_q <= '0;
                                ctrl_q    <= CTRL_RST;
                                clrcode_q <= '0;
                            end else if (rx_data[1]) begin
                                dac_out_q <= clrcode_q;
                            end else if (rx_data[0]) begin
                                dac_out_q <= dac_reg_q;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign miso       = miso_q;
    assign dac_out    = dac_out_q;
    assign ctrl_reg   = ctrl_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule
